// File: rtl/dsi_crc_append_stream_if.sv
// Byte-lane payload stream: valid/ready handshake plus last, byte-count and empty-payload marker.
interface dsi_crc_append_stream_if #(
    parameter int DATA_BYTES = 4
);
    localparam int BW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

    logic                    valid;
    logic                    ready;
    logic [8*DATA_BYTES-1:0] data;
    logic                    last;
    logic [BW-1:0]           bytes;
    logic                    nodata;

    modport master (output valid, data, last, bytes, nodata, input ready);
    modport slave  (input valid, data, last, bytes, nodata, output ready);
endinterface

// File: rtl/dsi_crc_append_stream.sv
// DSI long-packet payload CRC generator: registered pass-through stage that appends the
// 16-bit payload checksum as a footer, packed into free lanes of the last beat or spill beats.
module dsi_crc_append_stream #(
    parameter int          DATA_BYTES = 4,
    parameter logic [15:0] CRC_INIT   = 16'hFFFF,
    parameter bit          APPEND_CRC = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset,
    dsi_crc_append_stream_if.slave         s,
    dsi_crc_append_stream_if.master        m,
    output logic [15:0]                    crc_value,
    output logic                           crc_done,
    output logic                           err_proto
);
    localparam int         BW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int         DW = 8 * DATA_BYTES;
    localparam logic [3:0] NB = 4'(DATA_BYTES);

    typedef enum logic [1:0] {PASS, SPILL1, SPILL2} state_t;

    state_t          state_reg, state_next;
    logic            m_valid_reg, m_valid_next;
    logic [DW-1:0]   m_data_reg, m_data_next;
    logic            m_last_reg, m_last_next;
    logic [BW-1:0]   m_bytes_reg, m_bytes_next;
    logic            m_nodata_reg, m_nodata_next;
    logic [15:0]     crc_run_reg;
    logic [15:0]     crc_value_reg;
    logic            crc_done_reg;
    logic            err_proto_reg;

    logic            load;
    logic            accept;
    logic            drop;
    logic            footer;
    logic [3:0]      k;
    logic [3:0]      room;
    logic [15:0]     crc_acc;
    logic [DW-1:0]   pass_data;

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        end
        return r;
    endfunction

    assign load    = !m_valid_reg || m.ready;
    assign s.ready = (state_reg == PASS) && load;
    assign accept  = s.valid && s.ready;
    assign drop    = s.nodata && !s.last;
    assign footer  = APPEND_CRC && s.last;
    assign k       = s.nodata ? 4'd0 : (s.last ? (4'(s.bytes) + 4'd1) : NB);
    assign room    = NB - k;

    // Running CRC advanced over the k valid lanes of the incoming beat, lane 0 first.
    always_comb begin
        crc_acc = crc_run_reg;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (i < int'(k)) begin
                crc_acc = crc_byte(crc_acc, s.data[8*i +: 8]);
            end
        end
    end

    // Each output lane carries payload, a footer byte packed after the payload, or zero.
    generate
        for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_lane
            localparam logic [3:0] LN = 4'(gi);
            assign pass_data[8*gi +: 8] =
                (LN < k)                     ? s.data[8*gi +: 8] :
                (footer && LN == k)          ? crc_acc[7:0]      :
                (footer && LN == k + 4'd1)   ? crc_acc[15:8]     : 8'h00;
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        m_valid_next  = m_valid_reg;
        m_data_next   = m_data_reg;
        m_last_next   = m_last_reg;
        m_bytes_next  = m_bytes_reg;
        m_nodata_next = m_nodata_reg;
        if (load) begin
            m_valid_next  = 1'b0;
            m_data_next   = '0;
            m_last_next   = 1'b0;
            m_bytes_next  = '0;
            m_nodata_next = 1'b0;
            case (state_reg)
                PASS: begin
                    if (s.valid && !drop) begin
                        m_valid_next = 1'b1;
                        m_data_next  = pass_data;
                        if (!s.last) begin
                            m_bytes_next = BW'(NB - 4'd1);
                        end else if (!APPEND_CRC) begin
                            m_last_next   = 1'b1;
                            m_bytes_next  = s.nodata ? '0 : s.bytes;
                            m_nodata_next = s.nodata;
                        end else if (room >= 4'd2) begin
                            m_last_next  = 1'b1;
                            m_bytes_next = BW'(k + 4'd1);
                        end else if (room == 4'd1) begin
                            m_bytes_next = BW'(k);
                            state_next   = SPILL1;
                        end else begin
                            m_bytes_next = BW'(k - 4'd1);
                            state_next   = SPILL2;
                        end
                    end
                end
                // crc_value_reg holds the footer while draining; no new packet can complete here.
                SPILL2: begin
                    m_valid_next = 1'b1;
                    m_data_next  = DW'(crc_value_reg);
                    if (DATA_BYTES >= 2) begin
                        m_bytes_next = BW'(1);
                        m_last_next  = 1'b1;
                        state_next   = PASS;
                    end else begin
                        state_next   = SPILL1;
                    end
                end
                SPILL1: begin
                    m_valid_next = 1'b1;
                    m_data_next  = DW'(crc_value_reg[15:8]);
                    m_last_next  = 1'b1;
                    state_next   = PASS;
                end
                default: state_next = PASS;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= PASS;
            m_valid_reg   <= 1'b0;
            m_data_reg    <= '0;
            m_last_reg    <= 1'b0;
            m_bytes_reg   <= '0;
            m_nodata_reg  <= 1'b0;
            crc_run_reg   <= CRC_INIT;
            crc_value_reg <= 16'hFFFF;
            crc_done_reg  <= 1'b0;
            err_proto_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            m_valid_reg   <= m_valid_next;
            m_data_reg    <= m_data_next;
            m_last_reg    <= m_last_next;
            m_bytes_reg   <= m_bytes_next;
            m_nodata_reg  <= m_nodata_next;
            crc_done_reg  <= accept && s.last;
            err_proto_reg <= accept && drop;
            if (accept && !drop) begin
                crc_run_reg <= s.last ? CRC_INIT : crc_acc;
            end
            if (accept && s.last) begin
                crc_value_reg <= crc_acc;
            end
        end
    end

    assign m.valid   = m_valid_reg;
    assign m.data    = m_data_reg;
    assign m.last    = m_last_reg;
    assign m.bytes   = m_bytes_reg;
    assign m.nodata  = m_nodata_reg;
    assign crc_value = crc_value_reg;
    assign crc_done  = crc_done_reg;
    assign err_proto = err_proto_reg;
endmodule

// File: doc/dsi_crc_append_stream.md
Name: dsi_crc_append_stream

Overview:
- Streaming DSI long-packet payload CRC generator with a parametrised byte-lane width.
- Accepts payload beats on a valid/ready input and passes them through one registered output stage.
- Computes the 16-bit DSI payload checksum over the payload.
- Appends the checksum as a packet footer, packed into unused lanes of the last beat or into spill beats. Sits between the long-packet payload mux and the lane distributor.

Parameters:
- DATA_BYTES, 4, byte lanes per beat; legal values 1, 2, 4, 8; lane 0 = data[7:0] = first byte on the wire.
- CRC_INIT, 16'hFFFF, CRC seed loaded at reset and at each packet start.
- APPEND_CRC, 1, 1 = insert footer; 0 = pure pass-through, CRC still reported on crc_value.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid & s_ready
- s_data  in  8*DATA_BYTES  payload bytes
- s_last  in  1  last payload beat of packet
- s_bytes  in  max(1,log2(DATA_BYTES))  valid bytes minus 1; sampled on last beat only, non-last beats are full
- s_nodata  in  1  zero-length payload marker; legal only with s_last
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accept
- m_data  out  8*DATA_BYTES  payload/footer bytes, unused lanes 0
- m_last  out  1  final beat of packet including footer
- m_bytes  out  max(1,log2(DATA_BYTES))  valid bytes minus 1
- crc_value  out  16  checksum of most recently completed packet
- crc_done  out  1  one-cycle pulse when crc_value updates
- err_proto  out  1  one-cycle pulse: s_nodata without s_last

Behaviour:
- CRC definition:
  - Polynomial x^16+x^12+x^5+1, reflected (0x8408), seed CRC_INIT, no final XOR.
  - Bytes are processed lane 0 upward, each byte LSB first.
  - Footer order on the wire: crc[7:0] then crc[15:8].
- Reset: all outputs 0, state PASS, running CRC = CRC_INIT, crc_value = 16'hFFFF.
- Handshake:
  - The output register loads when it is empty or m_ready=1.
  - s_ready = (state==PASS) & (!m_valid | m_ready).
  - m_* remain stable while m_valid & !m_ready.
- Latency: an accepted input beat appears on m_* on the next cycle; zero bubbles at full throughput within a packet.
- Running CRC: updated combinationally across k = s_bytes+1 lanes on each accepted beat (0 lanes if s_nodata). It is registered on acceptance and reloads CRC_INIT after the last beat.
- Last beat, with k valid bytes and room = DATA_BYTES - k (k=0 for s_nodata):
  - APPEND_CRC=0: emit as received, m_last=1.
  - room >= 2: both CRC bytes go in lanes k, k+1; m_bytes = k+1; m_last=1; stay in PASS.
  - room == 1: lane k = crc[7:0]; m_last=0; go to SPILL1 (crc[15:8] pending).
  - room == 0: m_last=0; go to SPILL2.
- SPILL2:
  - DATA_BYTES >= 2: emit one beat with lanes 0,1 = crc lo,hi; m_bytes=1; m_last=1; go to PASS.
  - DATA_BYTES == 1: emit lo and go to SPILL1.
- SPILL1: emit one beat with lane 0 = crc hi, m_bytes=0, m_last=1; go to PASS.
- Spill beats are emitted on consecutive output-register loads. s_ready=0 throughout SPILL states.
- crc_value/crc_done: update/pulse in the cycle the last input beat is accepted, independent of footer drain.
- s_nodata without s_last:
  - Beat is accepted and dropped; nothing is output.
  - err_proto pulses; CRC is unchanged.
- s_bytes on a non-last beat is ignored.
- Reset mid-packet or mid-spill: immediate return to reset state, partial footer discarded, no crc_done.
- Back-to-back packets: a new packet may be accepted in the cycle the final footer beat loads the output register.

Test Plan:
- DATA_BYTES=4, payload ASCII "123456789" (beats 34333231, 38373635, then 39 with s_bytes=0) -> third output beat lanes {39,91,6F}, m_bytes=2, m_last=1; crc_value=16'h6F91; crc_done pulses once.
- DATA_BYTES=2, same payload -> five output beats, fifth {39,91} with m_last=0, then spill beat {6F}, m_bytes=0, m_last=1; s_ready low during spill.
- DATA_BYTES=1, same payload -> 9 data beats, then beats 91 and 6F; m_last only on 6F.
- DATA_BYTES=4, s_nodata & s_last -> one beat {FF,FF}, m_bytes=1, m_last=1; crc_value=16'hFFFF.
- DATA_BYTES=4, m_ready toggled randomly during "123456789" -> output sequence identical to the first case, no beat lost or duplicated, m_* stable while stalled.
- Assert reset in SPILL1, then send "123456789" -> clean output with crc 16'h6F91, no leftover footer; err_proto pulse when s_nodata is given without s_last.
